// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the CPU control path.
//   opcode_t : instruction opcodes, held at 8 bits so that any legal opcode
//              width (4..8) zero-extends onto the same constants
//   state_t  : sequencer run state
//   ctrl_t   : bundle of the datapath control strobes
//   lastStep : index of the final micro-step of each instruction
package cpu_pkg;

  typedef enum logic [7:0] {
    NOP = 8'h00,
    LDA = 8'h01,
    ADD = 8'h02,
    SUB = 8'h03,
    STA = 8'h04,
    LDI = 8'h05,
    JMP = 8'h06,
    JC  = 8'h07,
    JZ  = 8'h08,
    OUT = 8'h0E,
    HLT = 8'h0F
  } opcode_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic addressWEN;
    logic ramWEN;
    logic ramREN;
    logic iWEN;
    logic iREN;
    logic aWEN;
    logic aREN;
    logic aluREN;
    logic sub;
    logic bWEN;
    logic outputWEN;
    logic pcEN;
    logic pcREN;
    logic jump;
    logic flagWEN;
  } ctrl_t;

  // Last micro-step of each instruction; everything not listed ends at T2.
  function automatic int lastStep(opcode_t op);
    case (op)
      LDA, STA: return 3;
      ADD, SUB: return 4;
      default:  return 2;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// step_counter -- micro-step index register.
//   CLK, nRST : clock, asynchronous active-low reset
//   clear     : load 0 on the next edge (has priority over hold)
//   hold      : keep the current value
//   count     : current step index
module step_counter #(
  parameter int SW = 3
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clear,
  input  logic          hold,
  output logic [SW-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + SW'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer -- micro-step sequencer of a small accumulator CPU.
//   CLK, nRST      : clock, asynchronous active-low reset
//   opcode         : opcode field of the instruction register (OPW bits)
//   zero, carry    : latched ALU flags, used only by JZ / JC in T2
//   stall          : memory not ready; freezes the step and mutes strobes
//   halt           : CPU halted (sticky until reset)
//   addressWEN..flagWEN : datapath control strobes
//   step           : current micro-step index
//   instr_done     : current step is the final step of the instruction
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int STEPS = 8,
  localparam int SW   = $clog2(STEPS)
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           carry,
  input  logic           stall,
  output logic           halt,
  output logic           addressWEN,
  output logic           ramWEN,
  output logic           ramREN,
  output logic           iWEN,
  output logic           iREN,
  output logic           aWEN,
  output logic           aREN,
  output logic           aluREN,
  output logic           sub,
  output logic           bWEN,
  output logic           outputWEN,
  output logic           pcEN,
  output logic           pcREN,
  output logic           jump,
  output logic           flagWEN,
  output logic [SW-1:0]  step,
  output logic           instr_done
);

  state_t      state, nextState;
  opcode_t     op;
  ctrl_t       ctrl;
  logic [7:0]  opExt;
  logic        haltNow;
  logic        atWrap;
  logic        stepClear;
  logic        stepHold;

  // Zero-extend so the full opcode is compared; upper bits set means NOP.
  assign opExt = 8'(opcode);

  always_comb begin
    case (opExt)
      LDA, ADD, SUB, STA, LDI, JMP, JC, JZ, OUT, HLT: op = opcode_t'(opExt);
      default:                                      op = NOP;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    ctrl       = '0;
    haltNow    = 1'b0;
    instr_done = 1'b0;
    if (state == RUN && !stall) begin
      case (int'(step))
        0: begin
          ctrl.addressWEN = 1'b1;
          ctrl.pcREN      = 1'b1;
        end
        1: begin
          ctrl.ramREN = 1'b1;
          ctrl.iWEN   = 1'b1;
          ctrl.pcEN   = 1'b1;
        end
        2: begin
          case (op)
            LDA, ADD, SUB, STA: begin
              ctrl.addressWEN = 1'b1;
              ctrl.iREN       = 1'b1;
            end
            LDI: begin
              ctrl.iREN = 1'b1;
              ctrl.aWEN = 1'b1;
            end
            JMP: begin
              ctrl.iREN = 1'b1;
              ctrl.jump = 1'b1;
            end
            JC: begin
              ctrl.iREN = carry;
              ctrl.jump = carry;
            end
            JZ: begin
              ctrl.iREN = zero;
              ctrl.jump = zero;
            end
            OUT: begin
              ctrl.aREN      = 1'b1;
              ctrl.outputWEN = 1'b1;
            end
            HLT:     haltNow = 1'b1;
            default: ;
          endcase
        end
        3: begin
          case (op)
            LDA: begin
              ctrl.ramREN = 1'b1;
              ctrl.aWEN   = 1'b1;
            end
            ADD, SUB: begin
              ctrl.ramREN = 1'b1;
              ctrl.bWEN   = 1'b1;
            end
            STA: begin
              ctrl.ramWEN = 1'b1;
              ctrl.aREN   = 1'b1;
            end
            default: ;
          endcase
        end
        4: begin
          if (op == ADD || op == SUB) begin
            ctrl.aWEN    = 1'b1;
            ctrl.aluREN  = 1'b1;
            ctrl.flagWEN = 1'b1;
            ctrl.sub     = (op == SUB);
          end
        end
        default: ;
      endcase
      instr_done = (int'(step) == lastStep(op));
    end
  end

  always_comb begin
    nextState = state;
    if (haltNow) nextState = HALTED;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= nextState;
  end

  // A step that reaches the top of the range without finishing is a decode
  // fault; restart the fetch rather than wrap through undefined steps.
  assign atWrap    = (step == SW'(STEPS - 1));
  assign stepClear = (state == HALTED) || instr_done ||
                     (state == RUN && !stall && atWrap);
  assign stepHold  = (state == RUN) && stall;

  step_counter #(.SW(SW)) u_stepCounter (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (stepClear),
    .hold  (stepHold),
    .count (step)
  );

  assign halt       = (state == HALTED) || haltNow;
  assign addressWEN = ctrl.addressWEN;
  assign ramWEN     = ctrl.ramWEN;
  assign ramREN     = ctrl.ramREN;
  assign iWEN       = ctrl.iWEN;
  assign iREN       = ctrl.iREN;
  assign aWEN       = ctrl.aWEN;
  assign aREN       = ctrl.aREN;
  assign aluREN     = ctrl.aluREN;
  assign sub        = ctrl.sub;
  assign bWEN       = ctrl.bWEN;
  assign outputWEN  = ctrl.outputWEN;
  assign pcEN       = ctrl.pcEN;
  assign pcREN      = ctrl.pcREN;
  assign jump       = ctrl.jump;
  assign flagWEN    = ctrl.flagWEN;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer -- self-checking bench for control_sequencer.
// Two instances: the default (OPW=4) and OPW=6. A behavioural model tracks
// step and halt for each, and a compare process checks all outputs on every
// falling edge. Directed scenarios add literal expectations.
// Output vector bit order: 0 addressWEN, 1 ramWEN, 2 ramREN, 3 iWEN, 4 iREN,
// 5 aWEN, 6 aREN, 7 aluREN, 8 sub, 9 bWEN, 10 outputWEN, 11 pcEN, 12 pcREN,
// 13 jump, 14 flagWEN, 15 instr_done, 16 halt.
module tb_control_sequencer;

  localparam int STEPS = 8;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // instance 0: OPW = 4
  logic [3:0] op0;
  logic       zero0, carry0, stall0;
  logic       halt0, done0;
  logic [2:0] step0;
  logic [14:0] stb0;
  // instance 1: OPW = 6
  logic [5:0] op1;
  logic       zero1, carry1, stall1;
  logic       halt1, done1;
  logic [2:0] step1;
  logic [14:0] stb1;

  control_sequencer u_dut (
    .CLK(CLK), .nRST(nRST), .opcode(op0), .zero(zero0), .carry(carry0),
    .stall(stall0), .halt(halt0),
    .addressWEN(stb0[0]), .ramWEN(stb0[1]), .ramREN(stb0[2]), .iWEN(stb0[3]),
    .iREN(stb0[4]), .aWEN(stb0[5]), .aREN(stb0[6]), .aluREN(stb0[7]),
    .sub(stb0[8]), .bWEN(stb0[9]), .outputWEN(stb0[10]), .pcEN(stb0[11]),
    .pcREN(stb0[12]), .jump(stb0[13]), .flagWEN(stb0[14]),
    .step(step0), .instr_done(done0)
  );

  control_sequencer #(.OPW(6)) u_dut6 (
    .CLK(CLK), .nRST(nRST), .opcode(op1), .zero(zero1), .carry(carry1),
    .stall(stall1), .halt(halt1),
    .addressWEN(stb1[0]), .ramWEN(stb1[1]), .ramREN(stb1[2]), .iWEN(stb1[3]),
    .iREN(stb1[4]), .aWEN(stb1[5]), .aREN(stb1[6]), .aluREN(stb1[7]),
    .sub(stb1[8]), .bWEN(stb1[9]), .outputWEN(stb1[10]), .pcEN(stb1[11]),
    .pcREN(stb1[12]), .jump(stb1[13]), .flagWEN(stb1[14]),
    .step(step1), .instr_done(done1)
  );

  logic [16:0] vec0, vec1;
  assign vec0 = {halt0, done0, stb0};
  assign vec1 = {halt1, done1, stb1};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int lastOf(input int op);
    if (op == 1 || op == 4) return 3;
    if (op == 2 || op == 3) return 4;
    return 2;
  endfunction

  function automatic logic [16:0] expOut(input int op, input int st,
                                         input bit z, input bit c,
                                         input bit stl, input bit halted);
    logic [16:0] o;
    o = '0;
    if (halted) begin
      o[16] = 1'b1;
      return o;
    end
    if (stl) return o;
    if (st == 0) begin o[0] = 1; o[12] = 1; end
    if (st == 1) begin o[2] = 1; o[3] = 1; o[11] = 1; end
    if (st == 2) begin
      if (op >= 1 && op <= 4) begin o[0] = 1; o[4] = 1; end
      if (op == 5)            begin o[4] = 1; o[5] = 1; end
      if (op == 6)            begin o[4] = 1; o[13] = 1; end
      if (op == 7 && c)       begin o[4] = 1; o[13] = 1; end
      if (op == 8 && z)       begin o[4] = 1; o[13] = 1; end
      if (op == 14)           begin o[6] = 1; o[10] = 1; end
      if (op == 15)           o[16] = 1;
    end
    if (st == 3) begin
      if (op == 1)              begin o[2] = 1; o[5] = 1; end
      if (op == 2 || op == 3)   begin o[2] = 1; o[9] = 1; end
      if (op == 4)              begin o[1] = 1; o[6] = 1; end
    end
    if (st == 4 && (op == 2 || op == 3)) begin
      o[5] = 1; o[7] = 1; o[14] = 1;
      o[8] = (op == 3);
    end
    if (st == lastOf(op)) o[15] = 1;
    return o;
  endfunction

  function automatic int nextStep(input int op, input int st, input bit stl,
                                  input bit halted);
    if (halted)              return 0;
    if (stl)                 return st;
    if (st == lastOf(op))    return 0;
    if (st == STEPS - 1)     return 0;
    return st + 1;
  endfunction

  int mStep [2] = '{0, 0};
  bit mHalt [2] = '{1'b0, 1'b0};

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mStep[0] <= 0; mStep[1] <= 0;
      mHalt[0] <= 1'b0; mHalt[1] <= 1'b0;
    end else begin
      mStep[0] <= nextStep(int'(op0), mStep[0], stall0, mHalt[0]);
      mStep[1] <= nextStep(int'(op1), mStep[1], stall1, mHalt[1]);
      mHalt[0] <= mHalt[0] || (!stall0 && op0 == 4'hF && mStep[0] == 2);
      mHalt[1] <= mHalt[1] || (!stall1 && op1 == 6'h0F && mStep[1] == 2);
    end
  end

  // Compare process: every falling edge, both instances.
  always @(negedge CLK) begin
    check("dut0_outputs", 32'(vec0),
          32'(expOut(int'(op0), mStep[0], zero0, carry0, stall0, mHalt[0])));
    check("dut0_step", 32'(step0), 32'(mStep[0]));
    check("dut6_outputs", 32'(vec1),
          32'(expOut(int'(op1), mStep[1], zero1, carry1, stall1, mHalt[1])));
    check("dut6_step", 32'(step1), 32'(mStep[1]));
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    op0 = '0; zero0 = 0; carry0 = 0; stall0 = 0;
    op1 = '0; zero1 = 0; carry1 = 0; stall1 = 0;

    // reset state
    @(negedge CLK);
    @(negedge CLK);
    check("reset_step", 32'(step0), 32'd0);
    check("reset_vec", 32'(vec0), 32'h1001);
    check("reset_halt", 32'(halt0), 32'd0);

    // ADD on dut0, opcode 0x12 (NOP) on dut6
    next();
    nRST = 1'b1;
    op0 = 4'h2;
    op1 = 6'h12;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next();
      @(negedge CLK);
      check("add_step", 32'(step0), (k == 5) ? 32'd0 : 32'(k));
      check("add_done", 32'(done0), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) check("add_t4_vec", 32'(vec0), 32'hC0A0);
      check("nop6_step", 32'(step1), 32'(k % 3));
      check("nop6_done", 32'(done1), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) check("nop6_t2_vec", 32'(vec1), 32'h8000);
    end

    // JC not taken
    next();
    op0 = 4'h7; carry0 = 1'b0;
    @(negedge CLK);
    check("jc0_step1", 32'(step0), 32'd1);
    next();
    @(negedge CLK);
    check("jc0_t2_vec", 32'(vec0), 32'h8000);
    next();
    @(negedge CLK);
    check("jc0_wrap", 32'(step0), 32'd0);

    // JC taken
    next();
    carry0 = 1'b1;
    next();
    @(negedge CLK);
    check("jc1_t2_vec", 32'(vec0), 32'hA010);
    next();
    @(negedge CLK);
    check("jc1_wrap", 32'(step0), 32'd0);

    // LDA with a 3-cycle stall at step 3
    next();
    op0 = 4'h1; carry0 = 1'b0;
    next();
    next();
    stall0 = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("stall_step", 32'(step0), 32'd3);
      check("stall_vec", 32'(vec0), 32'h0);
      next();
    end
    stall0 = 1'b0;
    @(negedge CLK);
    check("lda_t3_vec", 32'(vec0), 32'h8024);
    next();
    @(negedge CLK);
    check("lda_after_step", 32'(step0), 32'd0);
    check("lda_after_ram_a", 32'({stb0[2], stb0[5]}), 32'd0);

    // HLT, then stay halted for 10 cycles with random stall
    next();
    op0 = 4'hF;
    next();
    @(negedge CLK);
    check("hlt_t2_vec", 32'(vec0), 32'h18000);
    for (int k = 0; k < 10; k++) begin
      next();
      stall0 = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check("halted_halt", 32'(halt0), 32'd1);
      check("halted_step", 32'(step0), 32'd0);
    end

    // reset pulse releases halt
    #2;
    stall0 = 1'b0;
    nRST = 1'b0;
    #1;
    check("rst_halt", 32'(halt0), 32'd0);
    check("rst_vec", 32'(vec0), 32'h1001);
    next();
    nRST = 1'b1;
    op0 = 4'h1;

    // reset asserted at LDA step 3 clears step asynchronously
    next();
    next();
    next();
    @(negedge CLK);
    check("lda_pre_rst_step", 32'(step0), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_step", 32'(step0), 32'd0);
    check("async_rst_vec", 32'(vec0), 32'h1001);
    next();
    nRST = 1'b1;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      next();
      if (((mHalt[0] || mHalt[1]) && $urandom_range(0, 7) == 0) ||
          $urandom_range(0, 199) == 0) begin
        nRST = 1'b0;
        stall0 = 1'b0;
        stall1 = 1'b0;
      end else begin
        nRST = 1'b1;
        stall0 = ($urandom_range(0, 4) == 0);
        stall1 = ($urandom_range(0, 4) == 0);
      end
      op0    = 4'($urandom_range(0, 15));
      op1    = 6'($urandom_range(0, 63));
      zero0  = 1'($urandom_range(0, 1));
      carry0 = 1'($urandom_range(0, 1));
      zero1  = 1'($urandom_range(0, 1));
      carry1 = 1'($urandom_range(0, 1));
    end
    next();
    nRST = 1'b1;
    @(negedge CLK);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
